// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier sequencer for the EX-stage MUL path; freezes the pipeline while iterating.
// Optional build macro MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
`timescale 1ns/1ps

module mul_sequencer #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             stall,
    output logic             busy
);

    localparam int STEPS = WIDTH / STEP_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [WIDTH-1:0] partial, acc_step, mplier_shift;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

    // Partial product of one multiplier digit: sum of the shifted multiplicand per set bit.
    always_comb begin
        partial = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    assign acc_step     = acc + partial;
    assign mplier_shift = mplier >> STEP_BITS;

`ifdef MUL_EARLY_TERM_EN
    assign last_step = (cnt == CNT_W'(1)) || (mplier_shift == '0);
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = RUN;
                    stall      = 1'b1;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (abort)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    // Result is only written on the final step, so an aborted run leaves the previous product visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        mcand  <= operand_a;
                        mplier <= operand_b;
                        acc    <= '0;
                        cnt    <= CNT_W'(STEPS);
                    end
                end
                RUN: begin
                    if (!abort) begin
                        acc    <= acc_step;
                        mcand  <= mcand << STEP_BITS;
                        mplier <= mplier_shift;
                        cnt    <= cnt - CNT_W'(1);
                        if (last_step) result <= acc_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus queues expected (result, done-cycle) pairs, monitors pop on done.
// Latency expectations follow the MUL_EARLY_TERM_EN build macro.
`timescale 1ns/1ps

module tb_mul_sequencer;

    localparam int W = 32;
`ifdef MUL_EARLY_TERM_EN
    localparam int LAT_3X5 = 4, LAT_X2 = 3, LAT_3X0 = 2, LAT_2X3 = 3, LAT4_SQ = 6;
    localparam int RST_AT = 2, ABORT_AT = 2;
`else
    localparam int LAT_3X5 = 33, LAT_X2 = 33, LAT_3X0 = 33, LAT_2X3 = 33, LAT4_SQ = 9;
    localparam int RST_AT = 10, ABORT_AT = 5;
`endif
    localparam int HOLD      = 40;
    localparam int PERIOD    = LAT_2X3 + 1;
    localparam int N_RESTART = (HOLD + PERIOD - 1) / PERIOD;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    logic         clk, reset;
    logic         start, abort, start4, abort4;
    logic [W-1:0] op_a, op_b, op_a4, op_b4;
    logic [W-1:0] result, result4;
    logic         done, stall, busy, done4, stall4, busy4;

    exp_t q1[$], q4[$];
    exp_t e1, e4;
    int   cyc;
    int   errors, checks;

    mul_sequencer #(.WIDTH(W), .STEP_BITS(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .operand_a(op_a), .operand_b(op_b),
        .result(result), .done(done), .stall(stall), .busy(busy)
    );

    mul_sequencer #(.WIDTH(W), .STEP_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(abort4),
        .operand_a(op_a4), .operand_b(op_b4),
        .result(result4), .done(done4), .stall(stall4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q1.size() == 0) check("unexpected_done", done, 0);
            else begin
                e1 = q1.pop_front();
                check("result", result, e1.res);
                check("done_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done4) begin
            if (q4.size() == 0) check("unexpected_done4", done4, 0);
            else begin
                e4 = q4.pop_front();
                check("result4", result4, e4.res);
                check("done_cycle4", cyc, e4.cyc);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int lat);
        next_cycle();
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        q1.push_back('{res: exp_res, cyc: cyc + lat});
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || busy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("timeout_busy", busy | busy4, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0, bad, restarts;
        logic prev_busy;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;  abort  = 1'b0;  op_a  = '0;  op_b  = '0;
        start4 = 1'b0;  abort4 = 1'b0;  op_a4 = '0;  op_b4 = '0;

        // Reset state
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_result4", result4, 0);
        next_cycle();
        reset = 1'b0;

        // 3*5: stall window, done cycle, operands ignored during RUN
        next_cycle();
        start = 1'b1;  op_a = 3;  op_b = 5;
        c0 = cyc;
        q1.push_back('{res: 15, cyc: c0 + LAT_3X5});
        bad = 0;
        for (int i = 0; i < LAT_3X5; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) start = 1'b0;
            if (i == 2) begin op_a = 99; op_b = 77; end
            @(negedge clk);
            if (!stall) bad++;
        end
        check("stall_window_low_cycles", bad, 0);
        next_cycle();
        @(negedge clk);
        check("stall_in_done", stall, 0);
        check("done_at_latency", done, 1);
        wait_idle();

        // Reset in the middle of RUN (A=7, B=9)
        next_cycle();
        start = 1'b1;  op_a = 7;  op_b = 9;
        c0 = cyc;
        next_cycle();
        start = 1'b0;
        while (cyc < c0 + RST_AT) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_stall", stall, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);

        // Signed/overflow/zero vectors
        issue(32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, LAT_X2);
        wait_idle();
        issue(32'h8000_0000, 32'h0000_0002, 32'h0000_0000, LAT_X2);
        wait_idle();
        issue(32'h0000_0003, 32'h0000_0000, 32'h0000_0000, LAT_3X0);
        wait_idle();
        issue(32'h0000_0003, 32'h0000_0005, 32'h0000_000F, LAT_3X5);
        wait_idle();

        // Abort during RUN (A=4, B=4): no done, result keeps 15
        next_cycle();
        start = 1'b1;  op_a = 4;  op_b = 4;
        c0 = cyc;
        next_cycle();
        start = 1'b0;
        while (cyc < c0 + ABORT_AT) next_cycle();
        abort = 1'b1;
        @(negedge clk);
        check("abort_cycle_stall", stall, 1);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        repeat (40) next_cycle();
        check("abort_result_kept", result, 15);

        // Start and Abort together in IDLE
        next_cycle();
        start = 1'b1;  abort = 1'b1;  op_a = 5;  op_b = 5;
        @(negedge clk);
        check("start_abort_stall", stall, 0);
        next_cycle();
        start = 1'b0;  abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", busy, 0);

        // Start held high for HOLD cycles (A=2, B=3)
        next_cycle();
        start = 1'b1;  op_a = 2;  op_b = 3;
        c0 = cyc;
        for (int k = 0; k < N_RESTART; k++)
            q1.push_back('{res: 6, cyc: c0 + k * PERIOD + LAT_2X3});
        restarts  = 0;
        prev_busy = 1'b0;
        for (int i = 0; i <= HOLD + PERIOD + 2; i++) begin
            if (i > 0) next_cycle();
            if (i == HOLD) start = 1'b0;
            @(negedge clk);
            if (busy && !prev_busy) restarts++;
            prev_busy = busy;
            if (i == PERIOD) begin
                check("held_idle_busy", busy, 0);
                check("held_idle_stall", stall, 1);
            end
        end
        check("restart_count", restarts, N_RESTART);
        wait_idle();

        // STEP_BITS=4 instance: 0x00010001 squared
        next_cycle();
        start4 = 1'b1;  op_a4 = 32'h0001_0001;  op_b4 = 32'h0001_0001;
        q4.push_back('{res: 32'h0002_0001, cyc: cyc + LAT4_SQ});
        next_cycle();
        start4 = 1'b0;
        wait_idle();
        repeat (2) next_cycle();

        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
